// File: rtl/ysyx_ifu_pkg.sv
// Shared types for the ysyx instruction fetch unit: FSM states and buffer entry layout.
package ysyx_ifu_pkg;

    localparam int unsigned INST_W   = 32;
    localparam int unsigned IFU_XLEN = 32;

    typedef enum logic [1:0] {
        StReq,
        StWait,
        StDrop,
        StHalt
    } ifu_state_e;

    typedef struct packed {
        logic [IFU_XLEN-1:0] pc;
        logic [INST_W-1:0]   inst;
        logic                err;
    } ifu_entry_t;

    function automatic logic pc_misaligned(input logic [1:0] pc_lsb);
        return pc_lsb != 2'b00;
    endfunction

endpackage

// File: rtl/ysyx_ifu_fifo.sv
// Small synchronous FIFO holding fetched entries; flush clears it and wins over a push.
module ysyx_ifu_fifo #(
    parameter int unsigned Width = 65,
    parameter int unsigned Depth = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [Width-1:0]         wdata,
    output logic [Width-1:0]         rdata,
    output logic [$clog2(Depth):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AddrW = $clog2(Depth);

    logic [AddrW-1:0] wr_ptr_q;
    logic [AddrW-1:0] rd_ptr_q;
    logic [AddrW:0]   count_q;
    logic [Width-1:0] mem_q [Depth];
    logic             do_push;
    logic             do_pop;

    assign full    = count_q == (AddrW + 1)'(Depth);
    assign empty   = count_q == '0;
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AddrW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AddrW'(1);
            end
            count_q <= count_q + (AddrW + 1)'(do_push) - (AddrW + 1)'(do_pop);
        end
    end

    // Storage needs no reset; readers mask the head while empty.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/ysyx_ifu.sv
// Instruction fetch unit: one outstanding valid/ready request, PC-tagged responses queued for
// decode, redirects flush the queue and retire any stale response still in flight.
module ysyx_ifu
    import ysyx_ifu_pkg::*;
#(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = 32'h8000_0000,
    parameter int unsigned     BUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    output logic              req_valid,
    input  logic              req_ready,
    output logic [XLEN-1:0]   req_addr,
    input  logic              rsp_valid,
    input  logic [INST_W-1:0] rsp_data,
    input  logic              rsp_err,
    input  logic              redirect,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] out_inst,
    output logic [XLEN-1:0]   out_pc,
    output logic              out_err,
    output logic [XLEN-1:0]   fetch_pc
);

    localparam int unsigned EntryW = XLEN + INST_W + 1;
    localparam int unsigned CntW   = $clog2(BUF_DEPTH) + 1;

    ifu_state_e        state_q, state_d;
    logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
    logic              push, pop, flush;
    logic [EntryW-1:0] push_data;
    logic [EntryW-1:0] head_data;
    logic [CntW-1:0]   buf_count;
    logic              buf_full, buf_empty;
    logic              misaligned;
    logic              req_fire;

    assign misaligned = pc_misaligned(fetch_pc_q[1:0]);
    // Gated by rst so no request appears while reset is held.
    assign req_valid  = rst & (state_q == StReq) & ~buf_full & ~misaligned;
    assign req_fire   = req_valid & req_ready;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        push       = 1'b0;
        flush      = 1'b0;
        push_data  = {fetch_pc_q, rsp_data, rsp_err};
        if (redirect) begin
            flush      = 1'b1;
            fetch_pc_d = redirect_pc;
            unique case (state_q)
                StWait, StDrop: state_d = rsp_valid ? StReq : StDrop;
                StReq:          state_d = req_fire ? StDrop : StReq;
                StHalt:         state_d = StReq;
            endcase
        end else begin
            unique case (state_q)
                StReq: begin
                    if (!buf_full) begin
                        if (misaligned) begin
                            push      = 1'b1;
                            push_data = {fetch_pc_q, {INST_W{1'b0}}, 1'b1};
                            state_d   = StHalt;
                        end else if (req_ready) begin
                            state_d = StWait;
                        end
                    end
                end
                StWait: begin
                    if (rsp_valid) begin
                        push = 1'b1;
                        if (rsp_err) begin
                            state_d = StHalt;
                        end else begin
                            fetch_pc_d = fetch_pc_q + XLEN'(4);
                            state_d    = StReq;
                        end
                    end
                end
                StDrop: begin
                    if (rsp_valid) begin
                        state_d = StReq;
                    end
                end
                StHalt: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StReq;
            fetch_pc_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    ysyx_ifu_fifo #(
        .Width (EntryW),
        .Depth (BUF_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdata (push_data),
        .rdata (head_data),
        .count (buf_count),
        .full  (buf_full),
        .empty (buf_empty)
    );

    assign out_valid = (buf_count != '0) & ~redirect;
    assign pop       = out_valid & out_ready;

    always_comb begin
        {out_pc, out_inst, out_err} = buf_empty ? '0 : head_data;
    end

    assign req_addr = fetch_pc_q;
    assign fetch_pc = fetch_pc_q;

endmodule

// File: tb/tb_ysyx_ifu.sv
// Self-checking bench for ysyx_ifu: directed scenarios plus a randomized run against a
// transaction-level model of the fetch stream and a responding memory.
module tb_ysyx_ifu;
    import ysyx_ifu_pkg::*;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 2;
    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk;
    logic        rst;
    logic        req_valid, req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid, out_ready, out_err;
    logic [31:0] out_inst, out_pc, fetch_pc;

    ysyx_ifu #(
        .XLEN      (XLEN),
        .RESET_PC  (RST_PC),
        .BUF_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .rsp_err     (rsp_err),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_inst    (out_inst),
        .out_pc      (out_pc),
        .out_err     (out_err),
        .fetch_pc    (fetch_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Knobs steering the per-cycle driver.
    bit          k_rst, k_rand, k_req_ready, k_out_ready, k_redirect, k_fixed, k_rand_err;
    logic [31:0] k_redirect_pc, k_err_addr;
    int          k_lat;

    // Model: memory with one outstanding slot, fetch stream and expected pop stream.
    bit          m_out, m_stale, m_halted, m_pop_end;
    logic [31:0] m_pend, m_fetch, m_pop_pc;
    int          m_lat;

    int          cyc, hs_count, pop_count, first_pop_cyc;
    logic [31:0] first_hs_addr, last_hs_addr, last_pop_pc;
    logic        last_pop_err;

    logic        s_req_valid, s_out_valid, s_out_err;
    logic [31:0] s_req_addr, s_out_pc, s_out_inst, s_fetch_pc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return k_fixed ? 32'h0000_0013 : ((a * 32'h9e37_79b1) ^ 32'h5a5a_0000);
    endfunction

    function automatic logic mem_err(input logic [31:0] a);
        return (a == k_err_addr) || (k_rand_err && a[5:2] == 4'hf);
    endfunction

    function automatic logic [31:0] rand_pc();
        int sel;
        sel = $urandom_range(0, 15);
        if (sel == 0) return 32'h8000_0002 + 32'($urandom_range(0, 63)) * 4;
        if (sel == 1) return 32'hffff_fff0 + 32'($urandom_range(0, 3)) * 4;
        return 32'h8000_0000 + 32'($urandom_range(0, 63)) * 4;
    endfunction

    task automatic model_reset();
        m_out     = 0;
        m_stale   = 0;
        m_lat     = 0;
        m_pend    = '0;
        m_fetch   = RST_PC;
        m_halted  = 0;
        m_pop_pc  = RST_PC;
        m_pop_end = 0;
    endtask

    task automatic clr_stats();
        cyc           = 0;
        hs_count      = 0;
        pop_count     = 0;
        first_pop_cyc = -1;
        first_hs_addr = '0;
        last_hs_addr  = '0;
        last_pop_pc   = '0;
        last_pop_err  = 1'b0;
    endtask

    task automatic cycle();
        ifu_entry_t e;
        bit hs, pop, rsp;
        @(negedge clk);
        rst       = k_rst;
        rsp_valid = k_rst && m_out && (m_lat == 0);
        rsp_data  = mem_data(m_pend);
        rsp_err   = mem_err(m_pend);
        if (k_rand) begin
            req_ready   = ($urandom_range(0, 3) != 0);
            out_ready   = ($urandom_range(0, 2) != 0);
            redirect    = ($urandom_range(0, 24) == 0);
            redirect_pc = rand_pc();
        end else begin
            req_ready   = k_req_ready;
            out_ready   = k_out_ready;
            redirect    = k_redirect;
            redirect_pc = k_redirect_pc;
        end
        #1;
        s_req_valid = req_valid;
        s_req_addr  = req_addr;
        s_out_valid = out_valid;
        s_out_pc    = out_pc;
        s_out_inst  = out_inst;
        s_out_err   = out_err;
        s_fetch_pc  = fetch_pc;
        hs  = req_valid && req_ready;
        pop = out_valid && out_ready;
        rsp = rsp_valid;
        if (!k_rst) begin
            model_reset();
        end else begin
            if (m_out || m_halted) chk("no_request_allowed", 32'(req_valid), 32'd0);
            if (redirect) chk("redirect_gates_out_valid", 32'(out_valid), 32'd0);
            if (hs) begin
                chk("req_addr", req_addr, m_fetch);
                if (hs_count == 0) first_hs_addr = req_addr;
                last_hs_addr = req_addr;
                hs_count++;
            end
            if (pop) begin
                if (m_pop_end) begin
                    chk("pop_after_stream_end", 32'(out_valid), 32'd0);
                end else begin
                    e.pc   = m_pop_pc;
                    e.err  = (m_pop_pc[1:0] != 2'b00) || mem_err(m_pop_pc);
                    e.inst = (m_pop_pc[1:0] != 2'b00) ? 32'd0 : mem_data(m_pop_pc);
                    chk("pop_pc", out_pc, e.pc);
                    chk("pop_inst", out_inst, e.inst);
                    chk("pop_err", 32'(out_err), 32'(e.err));
                    if (e.err) m_pop_end = 1;
                    else m_pop_pc = m_pop_pc + 32'd4;
                end
                if (pop_count == 0) first_pop_cyc = cyc;
                last_pop_pc  = out_pc;
                last_pop_err = out_err;
                pop_count++;
            end
            if (m_out && rsp) begin
                m_out = 0;
                if (!m_stale && !redirect) begin
                    if (mem_err(m_pend)) m_halted = 1;
                    else m_fetch = m_fetch + 32'd4;
                end
            end else if (m_out) begin
                m_lat--;
                if (redirect) m_stale = 1;
            end
            if (hs) begin
                m_out   = 1;
                m_pend  = req_addr;
                m_lat   = k_rand ? $urandom_range(0, 2) : k_lat;
                m_stale = redirect;
            end
            if (redirect) begin
                m_fetch   = redirect_pc;
                m_halted  = (redirect_pc[1:0] != 2'b00);
                m_pop_pc  = redirect_pc;
                m_pop_end = 0;
            end
        end
        cyc++;
        @(posedge clk);
    endtask

    task automatic do_reset();
        k_rst = 0;
        cycle();
        cycle();
        k_rst = 1;
        clr_stats();
    endtask

    initial begin
        rst = 0; req_ready = 0; rsp_valid = 0; rsp_data = '0; rsp_err = 0;
        redirect = 0; redirect_pc = '0; out_ready = 0;
        k_rst = 0; k_rand = 0; k_req_ready = 1; k_out_ready = 1; k_redirect = 0;
        k_redirect_pc = '0; k_fixed = 1; k_rand_err = 0; k_err_addr = 32'h1; k_lat = 0;
        model_reset();
        clr_stats();

        // Reset values while rst is held low.
        cycle();
        cycle();
        chk("reset_req_valid", 32'(s_req_valid), 32'd0);
        chk("reset_out_valid", 32'(s_out_valid), 32'd0);
        chk("reset_out_inst", s_out_inst, 32'd0);
        chk("reset_out_pc", s_out_pc, 32'd0);
        chk("reset_out_err", 32'(s_out_err), 32'd0);
        chk("reset_fetch_pc", s_fetch_pc, RST_PC);

        // Streaming with a 1-cycle memory.
        k_rst = 1;
        clr_stats();
        cycle();
        chk("first_req_valid", 32'(s_req_valid), 32'd1);
        chk("first_req_addr", s_req_addr, RST_PC);
        repeat (9) cycle();
        chk("stream_hs_count", 32'(hs_count), 32'd5);
        chk("stream_first_pop_cycle", 32'(first_pop_cyc), 32'd2);
        chk("stream_pop_count", 32'(pop_count), 32'd4);
        chk("stream_last_addr", last_hs_addr, RST_PC + 32'h10);

        // Buffer fills while decode stalls, then drains.
        do_reset();
        k_out_ready = 0;
        repeat (12) cycle();
        chk("full_hs_count", 32'(hs_count), 32'(DEPTH));
        chk("full_req_valid", 32'(s_req_valid), 32'd0);
        chk("full_head_pc", s_out_pc, RST_PC);
        k_out_ready = 1;
        cycle();
        chk("credit_not_same_cycle", 32'(s_req_valid), 32'd0);
        cycle();
        chk("credit_next_cycle", 32'(s_req_valid), 32'd1);
        chk("resume_addr", s_req_addr, RST_PC + 32'(4 * DEPTH));

        // Redirect while waiting on a slow response.
        do_reset();
        k_out_ready = 0;
        cycle();
        cycle();
        k_lat = 3;
        cycle();
        k_redirect = 1;
        k_redirect_pc = 32'h8000_0100;
        cycle();
        chk("redirect_out_valid", 32'(s_out_valid), 32'd0);
        k_redirect = 0;
        k_lat = 0;
        clr_stats();
        cycle();
        chk("flushed_out_valid", 32'(s_out_valid), 32'd0);
        repeat (9) cycle();
        chk("redirect_first_addr", first_hs_addr, 32'h8000_0100);
        chk("redirect_head_pc", s_out_pc, 32'h8000_0100);

        // Misaligned redirect yields a single fault entry and halts.
        k_redirect = 1;
        k_redirect_pc = 32'h8000_0102;
        cycle();
        k_redirect = 0;
        clr_stats();
        repeat (5) cycle();
        chk("misaligned_valid", 32'(s_out_valid), 32'd1);
        chk("misaligned_pc", s_out_pc, 32'h8000_0102);
        chk("misaligned_err", 32'(s_out_err), 32'd1);
        chk("misaligned_inst", s_out_inst, 32'd0);
        chk("misaligned_no_req", 32'(hs_count), 32'd0);
        k_out_ready = 1;
        cycle();
        k_redirect = 1;
        k_redirect_pc = 32'h8000_0200;
        cycle();
        k_redirect = 0;
        clr_stats();
        repeat (4) cycle();
        chk("halt_resume_addr", first_hs_addr, 32'h8000_0200);

        // Access fault at the third fetch.
        do_reset();
        k_err_addr = 32'h8000_0008;
        repeat (14) cycle();
        chk("fault_hs_count", 32'(hs_count), 32'd3);
        chk("fault_fetch_pc", s_fetch_pc, 32'h8000_0008);
        chk("fault_pop_pc", last_pop_pc, 32'h8000_0008);
        chk("fault_pop_err", 32'(last_pop_err), 32'd1);
        k_err_addr = 32'h1;

        // PC wrap at the top of the address space.
        k_redirect = 1;
        k_redirect_pc = 32'hffff_fffc;
        cycle();
        k_redirect = 0;
        repeat (3) cycle();
        chk("wrap_fetch_pc", s_fetch_pc, 32'd0);
        chk("wrap_req_addr", s_req_addr, 32'd0);

        // Randomized traffic with a mid-run reset.
        k_rand = 1;
        k_fixed = 0;
        k_rand_err = 1;
        clr_stats();
        for (int i = 0; i < 4000; i++) begin
            if (i == 2000) begin
                k_rst = 0;
                cycle();
                cycle();
                chk("mid_reset_fetch_pc", s_fetch_pc, RST_PC);
                chk("mid_reset_out_valid", 32'(s_out_valid), 32'd0);
                chk("mid_reset_req_valid", 32'(s_req_valid), 32'd0);
                k_rst = 1;
            end
            cycle();
        end
        chk("random_liveness", 32'(hs_count > 200 && pop_count > 100), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
